// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin scheduler feeding an MSB-first serializer.
// Programmable bit hold time, optional even parity, frame strobe.
module piso_tx_arbiter #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             dout,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic             src
);

  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh;
  logic [HW-1:0]    hold;
  logic [BW-1:0]    bitc;
  logic             par;
  logic             ptr;

  logic             win;
  logic [WIDTH-1:0] cap;

  // Lone requester always wins; the pointer only breaks ties.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ptr;
    cap = win ? din1 : din0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sh    <= '0;
      hold  <= '0;
      bitc  <= '0;
      par   <= 1'b0;
      ptr   <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      dout  <= 1'b0;
      frame <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      src   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state <= S_SHIFT;
            sh    <= cap;
            par   <= ^cap;
            src   <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            frame <= 1'b1;
            busy  <= 1'b1;
            dout  <= cap[WIDTH-1];
            hold  <= '0;
            bitc  <= '0;
          end
        end
        S_SHIFT: begin
          if (hold == HOLD_LAST) begin
            hold <= '0;
            sh   <= sh << 1;
            if (bitc == BIT_LAST) begin
              bitc <= '0;
              if (PARITY_EN != 0) begin
                state <= S_PAR;
                dout  <= par;
              end else begin
                state <= S_DONE;
                dout  <= 1'b0;
                frame <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              bitc <= bitc + BW'(1);
              dout <= sh[WIDTH-2];
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        S_PAR: begin
          if (hold == HOLD_LAST) begin
            hold  <= '0;
            state <= S_DONE;
            dout  <= 1'b0;
            frame <= 1'b0;
            done  <= 1'b1;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ptr   <= ~src;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          frame <= 1'b0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: parity build (W4/BC1/P1) and hold build (W4/BC3/P0).
// Expected serial streams are queued at drive time and popped while frame is high.
module tb_piso_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, dout, frame, busy, done, src;

  logic       reqb0 = 1'b0, reqb1 = 1'b0;
  logic [3:0] dinb0 = '0, dinb1 = '0;
  logic       gnt0_b, gnt1_b, dout_b, frame_b, busy_b, done_b, src_b;

  piso_tx_arbiter #(.WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(1)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .dout(dout), .frame(frame),
    .busy(busy), .done(done), .src(src)
  );

  piso_tx_arbiter #(.WIDTH(4), .BIT_CYCLES(3), .PARITY_EN(0)) u_b (
    .clk(clk), .rst(rst),
    .req0(reqb0), .din0(dinb0), .req1(reqb1), .din1(dinb1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .dout(dout_b), .frame(frame_b),
    .busy(busy_b), .done(done_b), .src(src_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       r0;
    logic       r1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       src;
  } vec_t;

  vec_t vecs[6];

  logic [1:0] q_a[$];
  logic       q_b[$];
  logic       mon_en = 1'b1;
  int         fcnt_a = 0;
  int         fcnt_b = 0;
  logic       prev_frame_b = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      fcnt_a = 0;
    end else if (mon_en) begin
      logic [1:0] e;
      chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      if (frame) begin
        fcnt_a++;
        if (q_a.size() == 0) begin
          chk("frame_unexp", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          chk("dout_a", 32'(dout), 32'(e[0]));
          chk("src_a", 32'(src), 32'(e[1]));
        end
      end
      if (done) begin
        chk("done_len_a", 32'(fcnt_a), 32'd5);
        chk("done_flags_a", 32'({frame, busy, dout}), 32'b010);
        chk("done_q_a", 32'(q_a.size()), 32'd0);
        fcnt_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      fcnt_b = 0;
      prev_frame_b = 1'b0;
    end else begin
      if (frame_b) begin
        fcnt_b++;
        if (q_b.size() == 0) begin
          chk("frame_unexp_b", 32'd1, 32'd0);
        end else begin
          chk("dout_b", 32'(dout_b), 32'(q_b.pop_front()));
          chk("src_b", 32'(src_b), 32'd0);
        end
      end
      if (done_b) begin
        chk("frame_len_b", 32'(fcnt_b), 32'd12);
        chk("done_follows_b", 32'({prev_frame_b, frame_b, busy_b}), 32'b101);
        fcnt_b = 0;
      end
      prev_frame_b = frame_b;
    end
  end

  task automatic run_vec(input vec_t v);
    logic [3:0] w;
    int n;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; din0 = v.d0; din1 = v.d1;
    w = v.src ? v.d1 : v.d0;
    for (int i = 3; i >= 0; i--) q_a.push_back({v.src, w[i]});
    q_a.push_back({v.src, ^w});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 | gnt1) && n < 40);
    if (!(gnt0 | gnt1)) chk("gnt_timeout", 32'd0, 32'd1);
    else chk("gnt_a", 32'({gnt1, gnt0}), v.src ? 32'b10 : 32'b01);
    req0 = 1'b0; req1 = 1'b0;
    din0 = 4'($urandom); din1 = 4'($urandom);
    @(negedge clk);
    chk("gnt_pulse", 32'({gnt1, gnt0}), 32'd0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'({done, busy, frame}), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{r0: 1'b0, r1: 1'b1, d0: 4'b0000, d1: 4'b0111, src: 1'b1};
    vecs[1] = '{r0: 1'b1, r1: 1'b0, d0: 4'b1010, d1: 4'b0000, src: 1'b0};
    vecs[2] = '{r0: 1'b1, r1: 1'b1, d0: 4'b1010, d1: 4'b1100, src: 1'b1};
    vecs[3] = '{r0: 1'b1, r1: 1'b1, d0: 4'b1010, d1: 4'b1100, src: 1'b0};
    vecs[4] = '{r0: 1'b1, r1: 1'b1, d0: 4'b1010, d1: 4'b1100, src: 1'b1};
    vecs[5] = '{r0: 1'b1, r1: 1'b1, d0: 4'b0110, d1: 4'b0011, src: 1'b0};

    #12;
    chk("rst_outs_a", 32'({gnt0, gnt1, dout, frame, busy, done, src}), 32'd0);
    chk("rst_outs_b", 32'({gnt0_b, gnt1_b, dout_b, frame_b, busy_b, done_b, src_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Hold build: each bit of 1001 held three cycles.
    @(negedge clk);
    reqb0 = 1'b1; dinb0 = 4'b1001;
    for (int i = 3; i >= 0; i--) repeat (3) q_b.push_back(dinb0[i]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0_b && n < 40);
    chk("gnt_b", 32'({gnt1_b, gnt0_b}), 32'b01);
    reqb0 = 1'b0; dinb0 = 4'b0110;
    n = 0;
    while (!done_b && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen_b", 32'(done_b), 32'd1);
    @(negedge clk);
    chk("done_pulse_b", 32'({done_b, busy_b}), 32'd0);

    // Mid-frame abort: pointer is 1 here, so a reset is visible as src0 on a tie.
    mon_en = 1'b0;
    @(negedge clk);
    req1 = 1'b1; din1 = 4'b1011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt1 && n < 40);
    chk("gnt_abort", 32'({gnt1, gnt0}), 32'b10);
    req1 = 1'b0;
    @(negedge clk);
    chk("abort_mid", 32'({frame, busy, dout}), 32'b110);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_a", 32'({gnt0, gnt1, dout, frame, busy, done, src}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_rst", 32'({done, busy}), 32'd0);
    end
    rst = 1'b0;
    q_a.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'({busy, frame, done}), 32'd0);
    run_vec('{r0: 1'b1, r1: 1'b1, d0: 4'b1010, d1: 4'b0111, src: 1'b0});

    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
Two-requester round-robin scheduler and sequencer for a parallel-in/serial-out shift path. It grants the shared serializer to one requester, captures that requester's parallel word and shifts it out MSB-first. Each bit is held for a programmable number of clocks, with an optional even-parity bit. It sits between parallel producers and a single serial output line. Framing is carried on a separate `frame` strobe, so the line itself has no start or stop bits.

Parameters:
WIDTH, 4, data word width in bits (>=2)
BIT_CYCLES, 1, clock cycles each serial bit is held on dout (>=1)
PARITY_EN, 0, 1 = append one even-parity bit after the data bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 wants to send; held with din0 until gnt0
din0  input  WIDTH  requester 0 parallel word
req1  input  1  requester 1 wants to send; held with din1 until gnt1
din1  input  WIDTH  requester 1 parallel word
gnt0  output  1  one-cycle pulse: din0 captured
gnt1  output  1  one-cycle pulse: din1 captured
dout  output  1  serial data, MSB first
frame  output  1  high while dout carries a data or parity bit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last bit of a frame
src  output  1  requester id of the current or last frame; valid while frame or done is high

Behaviour:
- All outputs are registered.
- Reset, asynchronous and effective immediately, including mid-frame:
  - state=IDLE.
  - dout, frame, busy, done, gnt0, gnt1, src all 0.
  - shift register cleared.
  - round-robin pointer = 0.
  - An aborted frame produces no done pulse.
- States: IDLE, SHIFT, PAR, DONE.
- IDLE:
  - dout=0, frame=0.
  - On a rising edge with req0|req1 high, the winner is chosen:
    - only one request high: that one wins, regardless of the pointer (work-conserving).
    - both high: the requester named by the pointer wins.
  - Winner's din is loaded into the shift register, src=winner, state goes to SHIFT.
  - In the next cycle: gnt_winner=1 for exactly that cycle, frame=1, busy=1, dout = MSB of the captured word.
  - A request dropped before it is sampled is ignored and leaves no state behind.
- SHIFT:
  - dout = shift register MSB.
  - Bit-hold counter runs 0..BIT_CYCLES-1; when it wraps, the register shifts left by one and the bit counter advances.
  - After WIDTH bits have each been held BIT_CYCLES cycles: go to PAR if PARITY_EN=1, else DONE.
- PAR:
  - dout = XOR of the captured word (even parity), frame=1, held BIT_CYCLES cycles, then DONE.
- DONE, one cycle:
  - done=1, frame=0, dout=0, busy=1.
  - Pointer is set to the other requester (~src).
  - Next state IDLE.
- Timing:
  - frame length = (WIDTH+PARITY_EN)*BIT_CYCLES cycles.
  - Minimum issue interval = frame length + 2 (DONE + IDLE).
  - Requests arriving while busy wait; they do not preempt.
- Inputs din0/din1 may change freely after the gnt pulse; the captured copy is used.
- Counter widths: $clog2 of BIT_CYCLES and of WIDTH+1, with a minimum of 1 bit; no overflow past the terminal counts.

Test Plan:
1. Reset: assert rst mid-run -> dout, frame, busy, done, gnt0, gnt1, src = 0 within the same cycle; after release, state is IDLE and pointer=0.
2. WIDTH=4, BIT_CYCLES=1, PARITY_EN=1; req0 with din0=1010 -> gnt0 pulses 1 cycle; dout=1,0,1,0 then parity 0 across 5 frame cycles with src=0; then done=1 for 1 cycle.
3. req0 and req1 held together, din0=1010, din1=1100 -> order is req0 frame, req1 frame (dout 1,1,0,0, parity 0, src=1), then req0 frame; gnt0 and gnt1 alternate, never both high.
4. Pointer=0 and only req1 high, din1=0111 -> granted immediately; dout 0,1,1,1 then parity 1.
5. BIT_CYCLES=3, PARITY_EN=0, din0=1001 -> each bit held 3 cycles; frame high exactly 12 cycles; done follows the last bit.
6. Reset asserted after 2 bits of a frame -> frame and busy drop immediately; no done pulse; a fresh req0 afterwards sends a complete frame.
